// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg: shared types and defaults for the product accumulator.
// Optional saturation feature is selected by macro PROD_ACCUM_SAT_EN.
package prod_accum_pkg;

  // Accumulator control states: collecting a frame, or holding a finished sum
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } accState_e;

  localparam int SIZE_DEF  = 4;
  localparam int CNT_DEF   = 8;
  localparam int ACC_W_DEF = 12;

  // Width needed for a beat counter that must represent 0..cnt
  function automatic int cntWidth(input int cnt);
    return $clog2(cnt + 1);
  endfunction

endpackage

// File: rtl/prod_accum_if.sv
// prod_accum_if: product input and frame-sum output handshakes of prod_accum.
// acc_sat exists only when PROD_ACCUM_SAT_EN is defined.
interface prod_accum_if #(
  parameter int N     = 8,
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic [N-1:0]     in_data;
  logic             in_ready;
  logic             clr;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic [CNT_W-1:0] beat_cnt;
`ifdef PROD_ACCUM_SAT_EN
  logic             acc_sat;
`endif

  // Producer/sink side (multiplier feed plus result consumer)
  modport master (
`ifdef PROD_ACCUM_SAT_EN
    input  acc_sat,
`endif
    output in_valid, in_data, clr, acc_ready,
    input  in_ready, acc_out, acc_valid, beat_cnt
  );

  // Accumulator side
  modport slave (
`ifdef PROD_ACCUM_SAT_EN
    output acc_sat,
`endif
    input  in_valid, in_data, clr, acc_ready,
    output in_ready, acc_out, acc_valid, beat_cnt
  );

endinterface

// File: rtl/prod_accum_sat_add.sv
// sat_add: ACC_W-bit unsigned adder. With PROD_ACCUM_SAT_EN defined the result
// clamps to all-ones and ovf_o flags the clamp; otherwise it wraps.
module sat_add #(
  parameter int ACC_W = 12
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
`ifdef PROD_ACCUM_SAT_EN
  output logic             ovf_o,
`endif
  output logic [ACC_W-1:0] sum_o
);

`ifdef PROD_ACCUM_SAT_EN
  logic [ACC_W:0] wide;

  // Full-width sum; the carry out decides whether to clamp
  always_comb begin
    wide  = {1'b0, a_i} + {1'b0, b_i};
    ovf_o = wide[ACC_W];
    sum_o = wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
  end
`else
  // Plain modulo-2^ACC_W addition
  always_comb begin
    sum_o = a_i + b_i;
  end
`endif

endmodule

// File: rtl/prod_accum.sv
// prod_accum: sums frames of CNT unsigned products from the multiplier and
// offers each frame sum on a valid/ready output, stalling input while a sum
// waits. Optional saturation: define PROD_ACCUM_SAT_EN (adds acc_sat).
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int size  = SIZE_DEF,
  parameter int N     = size * 2,
  parameter int CNT   = CNT_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = cntWidth(CNT)
) (
  input  logic clk,
  input  logic rst_n,
  prod_accum_if.slave bus
);

  accState_e        state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] accOut_q;
  logic             accValid_q;
  logic [N-1:0]     inData;
  logic [ACC_W-1:0] accNext_d;
  logic             lastBeat;
`ifdef PROD_ACCUM_SAT_EN
  logic             addOvf;
  logic             satFlag_q;
  logic             accSat_q;
`endif

  assign inData   = bus.in_data;
  assign lastBeat = (cnt_q == CNT_W'(CNT - 1));

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a_i   (acc_q),
    .b_i   (ACC_W'(inData)),
`ifdef PROD_ACCUM_SAT_EN
    .ovf_o (addOvf),
`endif
    .sum_o (accNext_d)
  );

  // Frame FSM: accumulate accepted products, then hold the sum until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      accOut_q   <= '0;
      accValid_q <= 1'b0;
`ifdef PROD_ACCUM_SAT_EN
      satFlag_q  <= 1'b0;
      accSat_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.clr) begin
            acc_q     <= '0;
            cnt_q     <= '0;
`ifdef PROD_ACCUM_SAT_EN
            satFlag_q <= 1'b0;
`endif
          end else if (bus.in_valid) begin
            if (lastBeat) begin
              accOut_q   <= accNext_d;
              accValid_q <= 1'b1;
              acc_q      <= '0;
              cnt_q      <= '0;
              state_q    <= HOLD;
`ifdef PROD_ACCUM_SAT_EN
              accSat_q   <= satFlag_q | addOvf;
              satFlag_q  <= 1'b0;
`endif
            end else begin
              acc_q     <= accNext_d;
              cnt_q     <= cnt_q + CNT_W'(1);
`ifdef PROD_ACCUM_SAT_EN
              satFlag_q <= satFlag_q | addOvf;
`endif
            end
          end
        end
        HOLD: begin
          if (bus.acc_ready) begin
            accValid_q <= 1'b0;
            state_q    <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.acc_out   = accOut_q;
  assign bus.acc_valid = accValid_q;
  assign bus.beat_cnt  = cnt_q;
`ifdef PROD_ACCUM_SAT_EN
  assign bus.acc_sat   = accSat_q;
`endif

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed bench for prod_accum. Two instances share stimulus:
// dutA with the default 12-bit accumulator, dutB with a 10-bit one so the
// max-value frame exercises wrap (default) or saturation (PROD_ACCUM_SAT_EN).
module tb_prod_accum;
   import prod_accum_pkg::*;

   localparam int CW = cntWidth(8);

   logic clk;
   logic rst_n;
   int   testsRun;
   int   failCount;

   prod_accum_if #(.N(8), .ACC_W(12), .CNT_W(CW)) busA ();
   prod_accum_if #(.N(8), .ACC_W(10), .CNT_W(CW)) busB ();

   prod_accum #(.size(4), .CNT(8), .ACC_W(12)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busA)
   );

   prod_accum #(.size(4), .CNT(8), .ACC_W(10)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busB)
   );

   // 10 ns free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive identical inputs into both instances without advancing time
   task automatic driveInputs(input logic v, input logic [7:0] d,
                              input logic c, input logic r);
      busA.in_valid  = v;
      busA.in_data   = d;
      busA.clr       = c;
      busA.acc_ready = r;
      busB.in_valid  = v;
      busB.in_data   = d;
      busB.clr       = c;
      busB.acc_ready = r;
   endtask

   // Present inputs for one clock edge, then settle 1 ns past the edge
   task automatic applyStimulus(input logic v, input logic [7:0] d,
                                input logic c, input logic r);
      driveInputs(v, d, c, r);
      @(posedge clk);
      #1;
   endtask

   // One counted comparison
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Directed sequence
   initial begin
      testsRun  = 0;
      failCount = 0;
      rst_n     = 1'b0;
      driveInputs(1'b0, 8'd0, 1'b0, 1'b0);

      // Reset state
      #20;
      checkOutput("rst_acc_out", 32'(busA.acc_out), 32'd0);
      checkOutput("rst_acc_valid", 32'(busA.acc_valid), 32'd0);
      checkOutput("rst_beat_cnt", 32'(busA.beat_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      checkOutput("rst_in_ready", 32'(busA.in_ready), 32'd1);

      // Steady frame of 8 x 15, sink not ready
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'd15, 1'b0, 1'b0);
      checkOutput("steady_valid_before_last", 32'(busA.acc_valid), 32'd0);
      checkOutput("steady_beat_cnt7", 32'(busA.beat_cnt), 32'd7);
      applyStimulus(1'b1, 8'd15, 1'b0, 1'b0);
      driveInputs(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("steady_acc_valid", 32'(busA.acc_valid), 32'd1);
      checkOutput("steady_acc_out", 32'(busA.acc_out), 32'd120);
      checkOutput("steady_beat_cnt0", 32'(busA.beat_cnt), 32'd0);

      // Backpressure: offered products and a clr must not disturb the held sum
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'd99, (i == 2), 1'b0);
         checkOutput("bp_in_ready", 32'(busA.in_ready), 32'd0);
         checkOutput("bp_acc_out", 32'(busA.acc_out), 32'd120);
         checkOutput("bp_acc_valid", 32'(busA.acc_valid), 32'd1);
      end
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      driveInputs(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("take_acc_valid", 32'(busA.acc_valid), 32'd0);
      checkOutput("take_in_ready", 32'(busA.in_ready), 32'd1);
      checkOutput("take_beat_cnt", 32'(busA.beat_cnt), 32'd0);

      // Max products with gaps; ignored data during gaps
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'd225, 1'b0, 1'b0);
         if (i < 7) applyStimulus(1'b0, 8'd200, 1'b0, 1'b0);
      end
      driveInputs(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("max_acc_valid", 32'(busA.acc_valid), 32'd1);
      checkOutput("max_acc_out", 32'(busA.acc_out), 32'd1800);
      checkOutput("narrow_acc_valid", 32'(busB.acc_valid), 32'd1);
`ifdef PROD_ACCUM_SAT_EN
      checkOutput("narrow_acc_out_sat", 32'(busB.acc_out), 32'd1023);
      checkOutput("narrow_acc_sat", 32'(busB.acc_sat), 32'd1);
      checkOutput("max_acc_sat", 32'(busA.acc_sat), 32'd0);
`else
      checkOutput("narrow_acc_out_wrap", 32'(busB.acc_out), 32'd776);
`endif
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      driveInputs(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("max_take_valid", 32'(busA.acc_valid), 32'd0);

      // clr mid-frame discards partial sum and the same-cycle product
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'd72, 1'b0, 1'b0);
      checkOutput("clr_beat_cnt3", 32'(busA.beat_cnt), 32'd3);
      applyStimulus(1'b1, 8'd72, 1'b1, 1'b0);
      checkOutput("clr_beat_cnt0", 32'(busA.beat_cnt), 32'd0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'd1, 1'b0, 1'b0);
      driveInputs(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("clr_acc_valid", 32'(busA.acc_valid), 32'd1);
      checkOutput("clr_acc_out", 32'(busA.acc_out), 32'd8);
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      driveInputs(1'b0, 8'd0, 1'b0, 1'b0);

      // Asynchronous reset mid-frame
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'd50, 1'b0, 1'b0);
      driveInputs(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("midrst_beat_cnt2", 32'(busA.beat_cnt), 32'd2);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_beat_cnt0", 32'(busA.beat_cnt), 32'd0);
      checkOutput("midrst_acc_out", 32'(busA.acc_out), 32'd0);
      checkOutput("midrst_in_ready", 32'(busA.in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fresh frame after reset proves the partial sum was dropped
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'd10, 1'b0, 1'b0);
      driveInputs(1'b0, 8'd0, 1'b0, 1'b0);
      checkOutput("postrst_acc_out", 32'(busA.acc_out), 32'd80);
      checkOutput("postrst_acc_valid", 32'(busA.acc_valid), 32'd1);

      // Reset while holding drops the pending sum
      rst_n = 1'b0;
      #1;
      checkOutput("holdrst_acc_valid", 32'(busA.acc_valid), 32'd0);
      checkOutput("holdrst_acc_out", 32'(busA.acc_out), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
